// File: rtl/iq_avg_snap_pkg.sv
// Shared types and bit positions for the IQ-average snapshot capture path.
// Imported by the capture controller and anything decoding its status word.
package iq_avg_snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } snap_state_t;

    localparam int DONE_BIT = 31;
    localparam int BUSY_BIT = 30;
    localparam int MISS_BIT = 29;

    localparam int ARM_BIT    = 0;
    localparam int TRIGEN_BIT = 1;
    localparam int ABORT_BIT  = 2;

    function automatic logic is_busy(input snap_state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/iq_avg_snapshot_ctrl_rise_edge_det.sv
// 1-bit registered rising-edge detector.
// The history flop loads the live input during reset so a held level is not an edge.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;

    // track the previous input value; reset preloads it with the current input
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= d;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/iq_avg_snapshot_ctrl.sv
// Snapshot capture controller: arm/trigger, then a fixed-length burst of
// averaged I/Q words into the snapshot BRAM, with a software status word.
module iq_avg_snapshot_ctrl
    import iq_avg_snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl,
    input  logic              trig,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status
);

    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    snap_state_t state_q;
    snap_state_t state_d;

    logic [ADDR_W:0] count_q;
    logic            done_q;
    logic            miss_q;

    logic arm_edge;
    logic abort;
    logic trig_en;
    logic start;

    logic accept;
    logic arm_clr;
    logic set_done;
    logic set_miss;

    assign abort   = ctrl[ABORT_BIT];
    assign trig_en = ctrl[TRIGEN_BIT];
    assign start   = trig | ~trig_en;

    rise_edge_det u_arm_edge (
        .clk  (user_clk),
        .rst  (user_rst),
        .d    (ctrl[ARM_BIT]),
        .rise (arm_edge)
    );

    // state register
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, sample acceptance and sticky-flag strobes; abort wins over all
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        arm_clr  = 1'b0;
        set_done = 1'b0;
        set_miss = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_edge) begin
                    state_d = ST_ARMED;
                    arm_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                    accept  = din_valid;
                end
            end
            ST_CAPTURE: begin
                accept   = din_valid;
                set_miss = trig;
                if (din_valid && (count_q == LAST_IDX)) begin
                    state_d  = ST_DONE;
                    set_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            accept   = 1'b0;
            arm_clr  = 1'b0;
            set_done = 1'b0;
            set_miss = 1'b0;
        end
    end

    // word counter: cleared by a new arm, stepped by every accepted sample
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            count_q <= '0;
        end else if (arm_clr) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    // done and trig_missed flags, both cleared only by a new arm
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            done_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            if (arm_clr) begin
                done_q <= 1'b0;
            end else if (set_done) begin
                done_q <= 1'b1;
            end
            if (arm_clr) begin
                miss_q <= 1'b0;
            end else if (set_miss) begin
                miss_q <= 1'b1;
            end
        end
    end

    // one-cycle registered BRAM write port; address is the pre-increment count
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            bram_we <= accept;
            if (accept) begin
                bram_addr <= count_q[ADDR_W-1:0];
                bram_data <= din;
            end
        end
    end

    // status word assembled purely from flops, so it tracks the post-update state
    always_comb begin
        status              = '0;
        status[ADDR_W:0]    = count_q;
        status[DONE_BIT]    = done_q;
        status[BUSY_BIT]    = is_busy(state_q);
        status[MISS_BIT]    = miss_q;
    end

endmodule
